escalonador_processos: RTL and testbench
========================================

// Module: escalonador_processos
// PURPOSE
//  Round-robin process scheduler for the RVSP operating-system top level.
//  Decides when the SO/BIOS runs and when a user process runs, and which process runs (id_proc).
//  Counts each process's quantum, preempts the process when its quantum expires and frees its slot on HALT.
//  Sequences the context save/restore handshake with the CPU around every switch.
// PARAMETERS
//  N_PROC   3   number of user process slots; ids are 1..N_PROC, id 0 = SO
//  QUANTUM  8   run cycles per quantum (>=2); WAIT cycles are not counted
//  IDW      2   id_proc width, = clog2(N_PROC+1)
// PORTS
//  clk          in   1       system clock (divided clock); all logic on rising edge
//  reset        in   1       asynchronous, active-low; clears all state immediately
//  start        in   1       1-cycle pulse from SO: load ready_in and begin scheduling
//  ready_in     in   N_PROC  bit k = process k+1 loaded in its partition and runnable
//  HALT         in   1       running process executed halt (sampled only in S_RUN)
//  WAIT         in   1       CPU blocked on I/O confirm; freezes the quantum counter
//  ctx_ack      in   1       CPU finished the requested save/restore (level)
//  Sel_BIOS     out  1       1 = SO/BIOS instruction stream selected
//  id_proc      out  IDW     active process id; 0 while the SO runs
//  run_en       out  1       1 = CPU may advance the user process (S_RUN only)
//  ctx_save     out  1       request: store context of id_proc
//  ctx_restore  out  1       request: load context of id_proc
//  quantum_over out  1       1-cycle pulse on quantum expiry
//  all_done     out  1       1-cycle pulse when the last ready process halts
//  ready_mask   out  N_PROC  current runnable set (debug)
// BEHAVIOUR
//  Reset: state=S_SO, Sel_BIOS=1, id_proc=0, mask=0, counter=0, last=0.
//    All other outputs are 0.
//  Reset mid-operation (any state, including during a handshake) aborts at once and returns to the reset values.
//  S_SO: Sel_BIOS=1.
//    On start with ready_in!=0: mask<=ready_in, go to S_SEL.
//    start with ready_in==0 is ignored. start outside S_SO is ignored.
//  S_SEL (1 cycle): select the first set mask bit scanning ids last+1 .. N_PROC, then 1 .. last.
//    Set id_proc and last to it, clear the counter, go to S_RESTORE.
//    Sel_BIOS falls to 0 on entry to S_SEL.
//  S_RESTORE: hold ctx_restore=1 until ctx_ack is sampled high, then go to S_RUN on the next edge.
//  S_RUN: run_en=1. The counter increments on each cycle with WAIT=0 and holds while WAIT=1.
//    Expiry: WAIT=0 and counter==QUANTUM-1.
//      quantum_over pulses in that cycle; go to S_SAVE.
//    HALT=1: clear mask[id_proc-1]; no quantum_over, no save.
//      If the mask becomes 0: all_done pulses, id_proc<=0, go to S_SO. Otherwise go to S_SEL.
//    Simultaneous HALT and expiry: HALT wins; quantum_over stays 0.
//  S_SAVE: hold ctx_save=1 until ctx_ack is sampled high, then go to S_SEL.
//    With a single ready process the same id is reselected and a full save and restore is still performed.
//  ctx_ack is ignored outside S_SAVE and S_RESTORE.
//    An ack held high across the handshake completes the next handshake in its first cycle.
//  Latency:
//    start to ctx_restore is 2 cycles (S_SO, then S_SEL).
//    Expiry to ctx_save is 1 cycle.
//    Halt to ctx_restore of the next process is 2 cycles.
//  Only one of ctx_save, ctx_restore and run_en is ever high.
//  id_proc is stable from S_SEL through S_SAVE.
// TESTING
//  T1 reset low -> Sel_BIOS=1, id_proc=0, run_en=0, mask=0. Holding reset low in any state gives the same.
//  T2 (QUANTUM=4) start, ready_in=3'b101 -> id_proc=1, ctx_restore until ack.
//     Then 4 run cycles; quantum_over pulses on the 4th; ctx_save follows; after ack, id_proc=3.
//  T3 WAIT high for 3 cycles inside S_RUN -> counter frozen.
//     quantum_over occurs only after 4 WAIT-low cycles, i.e. 7 cycles in S_RUN.
//  T4 HALT in S_RUN of id 3 with mask 3'b101 -> mask=3'b001, no quantum_over, no ctx_save.
//     Next id_proc=1; HALT together with expiry behaves the same.
//  T5 HALT of the last ready process -> all_done pulses once; S_SO, Sel_BIOS=1, id_proc=0.
//     A new start restarts scheduling from id last+1.
//  T6 reset asserted during S_RESTORE with ctx_ack low -> ctx_restore drops asynchronously.
//     Later acks are ignored until the next start.

Source files
------------

// File: rtl/escalonador_processos.sv
// Round-robin process scheduler: alternates between the SO/BIOS and user
// processes. It counts each process's quantum, preempts the process when the
// quantum expires, and frees the process slot on HALT. It also drives the
// context save/restore handshake with the CPU around every switch.
module escalonador_processos #(
    parameter int N_PROC  = 3,
    parameter int QUANTUM = 8,
    parameter int IDW     = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [N_PROC-1:0] ready_in,
    input  logic              HALT,
    input  logic              WAIT,
    input  logic              ctx_ack,
    output logic              Sel_BIOS,
    output logic [IDW-1:0]    id_proc,
    output logic              run_en,
    output logic              ctx_save,
    output logic              ctx_restore,
    output logic              quantum_over,
    output logic              all_done,
    output logic [N_PROC-1:0] ready_mask
);

    localparam int CW = $clog2(QUANTUM);

    typedef enum logic [2:0] {
        S_SO,
        S_SEL,
        S_RESTORE,
        S_RUN,
        S_SAVE
    } state_t;

    state_t            state_q, state_nx;
    logic [IDW-1:0]    id_q, last_q, sel_id;
    logic [N_PROC-1:0] mask_q, mask_halt, rot;
    logic [CW-1:0]     cnt_q;
    logic              count_full, expiry;
    int                cand;

    // Bit j of rot is the slot j+1 places after the last selected id.
    assign rot        = N_PROC'({mask_q, mask_q} >> last_q);
    assign mask_halt  = mask_q & ~(N_PROC'(1) << (id_q - IDW'(1)));
    assign count_full = (cnt_q == CW'(QUANTUM - 1));
    assign expiry     = count_full && !WAIT;

    // Round-robin pick: the first runnable slot after the last selected id, wrapping.
    always_comb begin
        sel_id = id_q;
        cand   = 0;
        for (int j = N_PROC - 1; j >= 0; j--) begin
            if (rot[j]) begin
                cand = int'(last_q) + j + 1;
                if (cand > N_PROC) cand = cand - N_PROC;
                sel_id = IDW'(cand);
            end
        end
    end

    // Registers for the state, the current and last ids, the runnable mask and the quantum counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_SO;
            id_q    <= '0;
            last_q  <= '0;
            mask_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_nx;
            case (state_q)
                S_SO: begin
                    if (start && (|ready_in)) mask_q <= ready_in;
                end
                S_SEL: begin
                    id_q   <= sel_id;
                    last_q <= sel_id;
                    cnt_q  <= '0;
                end
                S_RUN: begin
                    if (HALT) begin
                        mask_q <= mask_halt;
                        if (mask_halt == '0) id_q <= '0;
                    end else if (!WAIT && !count_full) begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Next state and Moore/Mealy outputs; HALT takes priority over quantum expiry.
    always_comb begin
        state_nx     = state_q;
        Sel_BIOS     = 1'b0;
        run_en       = 1'b0;
        ctx_save     = 1'b0;
        ctx_restore  = 1'b0;
        quantum_over = 1'b0;
        all_done     = 1'b0;
        id_proc      = id_q;
        ready_mask   = mask_q;
        case (state_q)
            S_SO: begin
                Sel_BIOS = 1'b1;
                if (start && (|ready_in)) state_nx = S_SEL;
            end
            S_SEL: begin
                id_proc  = sel_id;
                state_nx = S_RESTORE;
            end
            S_RESTORE: begin
                ctx_restore = 1'b1;
                if (ctx_ack) state_nx = S_RUN;
            end
            S_RUN: begin
                run_en = 1'b1;
                if (HALT) begin
                    if (mask_halt == '0) begin
                        all_done = 1'b1;
                        state_nx = S_SO;
                    end else begin
                        state_nx = S_SEL;
                    end
                end else if (expiry) begin
                    quantum_over = 1'b1;
                    state_nx     = S_SAVE;
                end
            end
            S_SAVE: begin
                ctx_save = 1'b1;
                if (ctx_ack) state_nx = S_SEL;
            end
            default: state_nx = S_SO;
        endcase
    end

endmodule

// File: tb/tb_escalonador_processos.sv
// Bench for escalonador_processos: directed scenarios plus random traffic,
// all compared cycle by cycle against a behavioural scheduler model.
module tb_escalonador_processos;

    localparam int N   = 3;
    localparam int Q   = 4;
    localparam int IDW = 2;

    localparam int M_SO    = 0;
    localparam int M_PICK  = 1;
    localparam int M_LOAD  = 2;
    localparam int M_EXEC  = 3;
    localparam int M_STORE = 4;

    logic           clk = 1'b0;
    logic           reset, start, HALT, WAIT, ctx_ack;
    logic [N-1:0]   ready_in;
    logic           Sel_BIOS, run_en, ctx_save, ctx_restore, quantum_over, all_done;
    logic [IDW-1:0] id_proc;
    logic [N-1:0]   ready_mask;

    int n_vec = 0;
    int n_err = 0;

    // model state
    int          m_mode, m_cur, m_last, m_used;
    bit          m_ready [N];
    logic [10:0] exp_vec;

    escalonador_processos #(.N_PROC(N), .QUANTUM(Q), .IDW(IDW)) dut (
        .clk(clk), .reset(reset), .start(start), .ready_in(ready_in),
        .HALT(HALT), .WAIT(WAIT), .ctx_ack(ctx_ack),
        .Sel_BIOS(Sel_BIOS), .id_proc(id_proc), .run_en(run_en),
        .ctx_save(ctx_save), .ctx_restore(ctx_restore),
        .quantum_over(quantum_over), .all_done(all_done), .ready_mask(ready_mask)
    );

    always #5 clk = ~clk;

    function automatic int m_count();
        int c;
        c = 0;
        for (int k = 0; k < N; k++) if (m_ready[k]) c++;
        return c;
    endfunction

    function automatic int m_pick();
        int id;
        for (int k = 1; k <= N; k++) begin
            id = (m_last + k - 1) % N + 1;
            if (m_ready[id-1]) return id;
        end
        return m_cur;
    endfunction

    function automatic logic [10:0] m_expect();
        logic [N-1:0] msk;
        int id, left;
        for (int k = 0; k < N; k++) msk[k] = m_ready[k];
        id   = (m_mode == M_PICK) ? m_pick() : m_cur;
        left = m_count() - ((m_mode == M_EXEC && HALT) ? 1 : 0);
        return {m_mode == M_SO, 2'(id), m_mode == M_EXEC, m_mode == M_STORE, m_mode == M_LOAD,
                m_mode == M_EXEC && !HALT && !WAIT && (m_used + 1 == Q),
                m_mode == M_EXEC && HALT && left == 0, msk};
    endfunction

    function automatic logic [10:0] obs();
        return {Sel_BIOS, id_proc, run_en, ctx_save, ctx_restore, quantum_over, all_done, ready_mask};
    endfunction

    task automatic m_reset();
        m_mode = M_SO; m_cur = 0; m_last = 0; m_used = 0;
        for (int k = 0; k < N; k++) m_ready[k] = 1'b0;
    endtask

    task automatic m_step();
        case (m_mode)
            M_SO: if (start && ready_in != 0) begin
                for (int k = 0; k < N; k++) m_ready[k] = ready_in[k];
                m_mode = M_PICK;
            end
            M_PICK: begin
                m_cur = m_pick(); m_last = m_cur; m_used = 0; m_mode = M_LOAD;
            end
            M_LOAD: if (ctx_ack) m_mode = M_EXEC;
            M_EXEC: begin
                if (HALT) begin
                    m_ready[m_cur-1] = 1'b0;
                    if (m_count() == 0) begin m_cur = 0; m_mode = M_SO; end
                    else m_mode = M_PICK;
                end else if (!WAIT) begin
                    if (m_used + 1 == Q) m_mode = M_STORE;
                    else m_used++;
                end
            end
            M_STORE: if (ctx_ack) m_mode = M_PICK;
            default: m_mode = M_SO;
        endcase
    endtask

    task automatic drive(input bit s, input logic [N-1:0] r, input bit h, input bit w, input bit a);
        start = s; ready_in = r; HALT = h; WAIT = w; ctx_ack = a;
        @(negedge clk);
        exp_vec = m_expect();
    endtask

    task automatic advance();
        @(posedge clk);
        if (reset) m_step();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0; m_reset();
        drive(0, '0, 0, 0, 0);
        advance();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0; m_reset();
        drive(0, '0, 0, 0, 0);
        n_vec++;
        if (obs() !== exp_vec) begin
            n_err++; $display("FAIL reset_model: got %b expected %b", obs(), exp_vec);
        end
        n_vec++;
        if ({Sel_BIOS, id_proc, run_en, ready_mask, ctx_save, ctx_restore} !== 9'b1_00_0_000_0_0) begin
            n_err++; $display("FAIL reset_values: got %b expected 100000000",
                              {Sel_BIOS, id_proc, run_en, ready_mask, ctx_save, ctx_restore});
        end
        advance();
        reset = 1'b1;
    endtask

    task automatic test_rotation();
        int first_rst = -1, first_id = -1, runs = 0, next_id = -1;
        bit saw_qo = 0, saw_save = 0;
        do_reset();
        for (int c = 0; c < 24; c++) begin
            drive(c == 0, 3'b101, 0, 0, (c % 4) == 3);
            n_vec++;
            if (obs() !== exp_vec) begin
                n_err++; $display("FAIL rotation c%0d: got %b expected %b", c, obs(), exp_vec);
            end
            if (ctx_restore && first_rst < 0) begin first_rst = c; first_id = int'(id_proc); end
            if (run_en && !saw_qo) runs++;
            if (quantum_over) saw_qo = 1;
            if (ctx_save) saw_save = 1;
            if (saw_save && ctx_restore && next_id < 0) next_id = int'(id_proc);
            advance();
        end
        n_vec++;
        if (first_rst !== 2) begin n_err++; $display("FAIL start_latency: got %0d expected 2", first_rst); end
        n_vec++;
        if (first_id !== 1) begin n_err++; $display("FAIL first_id: got %0d expected 1", first_id); end
        n_vec++;
        if (runs !== Q) begin n_err++; $display("FAIL quantum_len: got %0d expected %0d", runs, Q); end
        n_vec++;
        if (next_id !== 3) begin n_err++; $display("FAIL next_id: got %0d expected 3", next_id); end
    endtask

    task automatic test_wait();
        int runs = 0;
        bit got_qo = 0, w;
        do_reset();
        for (int c = 0; c < 30; c++) begin
            w = (m_mode == M_EXEC && runs >= 1 && runs <= 3);
            drive(c == 0, 3'b010, 0, w, 1);
            n_vec++;
            if (obs() !== exp_vec) begin
                n_err++; $display("FAIL wait c%0d: got %b expected %b", c, obs(), exp_vec);
            end
            if (run_en && !got_qo) runs++;
            if (quantum_over) got_qo = 1;
            advance();
        end
        n_vec++;
        if (runs !== 7) begin n_err++; $display("FAIL wait_freeze: got %0d run cycles expected 7", runs); end
    endtask

    task automatic test_halt(input int halt_at);
        int r3 = 0, next_id = -1;
        bit h, halted = 0, halt_qo = 0, saved = 0, taken = 0;
        logic [N-1:0] mask_after = 'x;
        do_reset();
        for (int c = 0; c < 40; c++) begin
            h = (m_mode == M_EXEC && m_cur == 3 && r3 == halt_at - 1 && !halted);
            drive(c == 0, 3'b101, h, 0, 1);
            n_vec++;
            if (obs() !== exp_vec) begin
                n_err++; $display("FAIL halt%0d c%0d: got %b expected %b", halt_at, c, obs(), exp_vec);
            end
            if (halted && !taken) begin mask_after = ready_mask; taken = 1; end
            if (halted && next_id < 0 && ctx_save) saved = 1;
            if (halted && ctx_restore && next_id < 0) next_id = int'(id_proc);
            if (h) begin halted = 1; halt_qo = quantum_over; end
            if (m_mode == M_EXEC && m_cur == 3) r3++;
            advance();
        end
        n_vec++;
        if (!halted || halt_qo !== 1'b0) begin
            n_err++; $display("FAIL halt%0d_qo: got %b (reached %b) expected 0", halt_at, halt_qo, halted);
        end
        n_vec++;
        if (mask_after !== 3'b001) begin n_err++; $display("FAIL halt%0d_mask: got %b expected 001", halt_at, mask_after); end
        n_vec++;
        if (saved !== 1'b0) begin n_err++; $display("FAIL halt%0d_save: got %b expected 0", halt_at, saved); end
        n_vec++;
        if (next_id !== 1) begin n_err++; $display("FAIL halt%0d_next: got %0d expected 1", halt_at, next_id); end
    endtask

    task automatic test_all_done();
        int r = 0, dones = 0, so_cycles = 0, new_id = -1;
        bit h, s, halted = 0, restarted = 0, so_ok = 0;
        do_reset();
        for (int c = 0; c < 40; c++) begin
            h = (m_mode == M_EXEC && r == 1 && !halted);
            s = (c == 0) || (halted && !restarted && m_mode == M_SO && so_cycles >= 2);
            drive(s, (c == 0) ? 3'b010 : 3'b111, h, 0, 1);
            n_vec++;
            if (obs() !== exp_vec) begin
                n_err++; $display("FAIL alldone c%0d: got %b expected %b", c, obs(), exp_vec);
            end
            if (all_done) dones++;
            if (halted && !restarted) begin
                if (so_cycles == 0) so_ok = (Sel_BIOS === 1'b1 && id_proc === 2'd0 && run_en === 1'b0);
                so_cycles++;
            end
            if (restarted && ctx_restore && new_id < 0) new_id = int'(id_proc);
            if (h) halted = 1;
            if (s && c != 0) restarted = 1;
            if (m_mode == M_EXEC) r++;
            advance();
        end
        n_vec++;
        if (dones !== 1) begin n_err++; $display("FAIL all_done_count: got %0d expected 1", dones); end
        n_vec++;
        if (so_ok !== 1'b1) begin n_err++; $display("FAIL back_to_so: got %b expected 1", so_ok); end
        n_vec++;
        if (new_id !== 3) begin n_err++; $display("FAIL restart_id: got %0d expected 3", new_id); end
    endtask

    task automatic test_async_reset();
        int late = 0;
        do_reset();
        for (int c = 0; c < 3; c++) begin
            drive(c == 0, 3'b001, 0, 0, 0);
            n_vec++;
            if (obs() !== exp_vec) begin
                n_err++; $display("FAIL areset c%0d: got %b expected %b", c, obs(), exp_vec);
            end
            if (c < 2) advance();
        end
        #2 reset = 1'b0; m_reset();
        #1;
        n_vec++;
        if ({ctx_restore, Sel_BIOS, id_proc} !== 4'b0100) begin
            n_err++; $display("FAIL async_drop: got %b expected 0100", {ctx_restore, Sel_BIOS, id_proc});
        end
        drive(0, 3'b001, 0, 0, 1);
        advance();
        reset = 1'b1;
        for (int c = 0; c < 6; c++) begin
            drive(0, 3'b001, 0, 0, 1);
            n_vec++;
            if (obs() !== exp_vec) begin
                n_err++; $display("FAIL post_reset c%0d: got %b expected %b", c, obs(), exp_vec);
            end
            if (ctx_restore || run_en) late++;
            advance();
        end
        n_vec++;
        if (late !== 0) begin n_err++; $display("FAIL ack_ignored: got %0d active cycles expected 0", late); end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 149) == 0) begin
                reset = 1'b0; m_reset();
            end
            drive($urandom_range(0, 7) == 0, 3'($urandom_range(0, 7)), $urandom_range(0, 9) == 0,
                  $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)));
            n_vec++;
            if (obs() !== exp_vec) begin
                n_err++; $display("FAIL random c%0d: got %b expected %b", c, obs(), exp_vec);
            end
            advance();
            reset = 1'b1;
        end
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; ready_in = '0; HALT = 1'b0; WAIT = 1'b0; ctx_ack = 1'b0;
        m_reset();
        test_reset();
        test_rotation();
        test_wait();
        test_halt(1);
        test_halt(Q);
        test_all_done();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
